clkdiv_prog: RTL and testbench
==============================

Name: clkdiv_prog

Overview:
- Parametrised, runtime-programmable multi-channel clock divider.
- Generates, per channel, a one-cycle tick enable and a near-50% square wave derived from the single system clock.
- Replaces fixed power-of-two counter taps: each channel has an arbitrary integer divisor, loadable at runtime through a valid/ready config port.
- Provides glitch-free divisor changes and a global phase-align input.
- Feeds the game, random-generator and VGA timing logic.

Parameters:
- NCH, 3, number of divider channels (1..8).
- CW, 26, counter and divisor width in bits.
- DIV_RST_VEC, {26'd65536, 26'd2048, 26'd4}, packed NCH*CW reset divisors; channel i uses bits [i*CW +: CW].

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sync_i  input  1  one-cycle pulse; restarts all channel counters in phase.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config accepted when cfg_valid && cfg_ready.
- cfg_ch  input  3  target channel index.
- cfg_div  input  CW  new divisor for the target channel.
- tick_o  output  NCH  per-channel one-cycle enable, high on wrap.
- sq_o  output  NCH  per-channel square wave.
- busy_o  output  NCH  per-channel pending-update flag.

Behaviour:
- Reset (async, rst=1):
  - cnt[i]=0; div[i]=DIV_RST_VEC slice; pend[i]=0.
  - tick_o=0, sq_o=0, busy_o=0, cfg_ready=0 while rst is held.
  - cfg_ready rises the first cycle after rst deasserts.
- Per-channel counter, div>=2:
  - cnt counts 0..div-1, then wraps to 0.
  - tick_o[i] is a registered output: high for exactly one cycle, the cycle after cnt==div-1 is sampled. Period = div cycles.
  - sq_o[i] is registered: 1 when cnt >= (div>>1), else 0. High time = div - floor(div/2); odd divisors give the extra cycle high.
- div==1: tick_o[i]=1 every cycle; sq_o[i]=1 constant.
- div==0: channel halted. cnt held at 0; tick_o[i]=0; sq_o[i]=0.
- cfg_ready = !pend[cfg_ch]. Also 0 when cfg_ch >= NCH; such a request is never accepted.
- Accepted config:
  - Stores cfg_div into shadow[cfg_ch] and sets pend[cfg_ch].
  - busy_o mirrors pend.
- Apply rule, glitch-free:
  - A pending divisor loads into div[i] on the cycle the channel wraps (cnt==div-1), so the old period completes fully.
  - If the channel is halted (div==0), the load happens on the next cycle.
  - Loading clears pend[i]; cnt restarts at 0 under the new divisor.
  - Exception: if shadow==div, the load is identical, with no period disturbance.
- Simultaneous accept and apply on the same channel is impossible, because cfg_ready is low while pending.
- sync_i=1:
  - On the next edge, every cnt is set to 0.
  - Any pending divisor is applied immediately and its pend bit is cleared.
  - No tick is generated that cycle.
  - sync_i takes precedence over a normal wrap.
  - A config accept in the same cycle still stores into shadow/pend and is applied at a later wrap or sync.
- Arithmetic: compare cnt against div-1 computed in CW bits. No wrap-around hazard, because div==0 is handled separately.
- Reset mid-operation: all state returns to reset values immediately; pending updates are discarded.

Optional Feature:
- Macro: CLKDIV_TICKCNT_EN.
- Defined:
  - Adds output tickcnt_o (NCH*16 bits): a per-channel 16-bit free-running count of tick_o pulses.
  - Wraps 65535 -> 0; cleared by rst and by sync_i.
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
- Reset release with defaults -> ch0 tick every 4 cycles, sq_o[0] pattern 0,0,1,1. ch1 first tick 2048 cycles after rst falls. ch2 period 65536.
- Program ch0 cfg_div=5 mid-period:
  - The current 4-cycle period completes, then the period becomes 5 with sq high 3 / low 2.
  - busy_o[0]=1 from accept until the wrap.
  - cfg_ready=0 for a second ch0 write during that time.
- Program ch1 cfg_div=0 -> after the next wrap, tick_o[1] and sq_o[1] stay 0. Then program 7 -> applied the next cycle; first tick 7 cycles later.
- Program div=1 on ch2 (applied at its wrap) -> tick_o[2] continuously 1, sq_o[2]=1.
- sync_i pulse while ch0 is at cnt=2 with a pending div=3 -> all counters 0, pend cleared, no tick in that cycle, ch0 next tick 3 cycles later. All channels with equal divisors tick on the same cycle.
- cfg_ch=5 with NCH=3 -> cfg_ready=0, no state change. Assert rst during a pending update -> pend cleared, divisors back to DIV_RST_VEC.

Source files
------------

// File: rtl/clkdiv_prog.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_prog
// Description : Runtime-programmable multi-channel clock divider. Each channel
//               produces a one-cycle tick enable and a near-50% square wave
//               from the system clock. The divisor of each channel is loaded
//               through a valid/ready config port. A new divisor is held in a
//               shadow register and takes effect only when the channel wraps,
//               so no period is ever cut short. sync_i restarts every channel
//               in phase and applies any pending divisor at once.
//
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous active-high reset
//               sync_i     - one-cycle pulse, restarts all counters in phase
//               cfg_valid  - config request
//               cfg_ready  - config accepted when cfg_valid && cfg_ready
//               cfg_ch     - target channel index
//               cfg_div    - new divisor for the target channel
//               tick_o     - per-channel one-cycle enable, high on wrap
//               sq_o       - per-channel square wave
//               busy_o     - per-channel pending-update flag
//               tickcnt_o  - per-channel 16-bit tick count (optional)
//
// Options     : define CLKDIV_TICKCNT_EN to add tickcnt_o
//
// Revision    : 1.0 - initial release
// ============================================================================
module clkdiv_prog #(
    parameter int                NCH         = 3,
    parameter int                CW          = 26,
    parameter logic [NCH*CW-1:0] DIV_RST_VEC = {26'd65536, 26'd2048, 26'd4}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync_i,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic [CW-1:0]     cfg_div,
    output logic [NCH-1:0]    tick_o,
    output logic [NCH-1:0]    sq_o,
    output logic [NCH-1:0]    busy_o
`ifdef CLKDIV_TICKCNT_EN
    ,
    output logic [NCH*16-1:0] tickcnt_o
`endif
);

    localparam logic [CW-1:0] c_one = {{(CW-1){1'b0}}, 1'b1};

    logic           r_rdy_en;
    logic [NCH-1:0] w_pend;
    logic           w_sel_pend;
    logic           w_accept;

    // Holds cfg_ready low while reset is asserted and releases it on the
    // first clock edge afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
        end
    end

    // Pending flag of the addressed channel. An index outside the channel
    // range reads as "pending" so such a request is never accepted.
    always_comb begin
        w_sel_pend = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (cfg_ch == 3'(k)) begin
                w_sel_pend = w_pend[k];
            end
        end
    end

    assign cfg_ready = r_rdy_en & ~w_sel_pend;
    assign w_accept  = cfg_valid & cfg_ready;
    assign busy_o    = w_pend;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            localparam logic [2:0]    c_idx     = 3'(gi);
            localparam logic [CW-1:0] c_div_rst = DIV_RST_VEC[gi*CW +: CW];

            logic [CW-1:0] r_cnt;
            logic [CW-1:0] r_div;
            logic [CW-1:0] r_shadow;
            logic          r_pend;
            logic          r_tick;
            logic          r_sq;
            logic          w_halt;
            logic          w_wrap;
            logic          w_acc;

            // div==0 is tested first, so div-1 never underflows in use.
            assign w_halt = (r_div == '0);
            assign w_wrap = !w_halt && (r_cnt == (r_div - c_one));
            assign w_acc  = w_accept && (cfg_ch == c_idx);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt    <= '0;
                    r_div    <= c_div_rst;
                    r_shadow <= '0;
                    r_pend   <= 1'b0;
                    r_tick   <= 1'b0;
                    r_sq     <= 1'b0;
                end else begin
                    if (sync_i) begin
                        // Phase restart: no tick this cycle; the square wave
                        // restarts at count 0, which is high only for div==1.
                        r_cnt  <= '0;
                        r_tick <= 1'b0;
                        if (r_pend) begin
                            r_div  <= r_shadow;
                            r_pend <= 1'b0;
                            r_sq   <= (r_shadow == c_one);
                        end else begin
                            r_sq   <= (r_div == c_one);
                        end
                    end else if (w_halt) begin
                        // A halted channel has no wrap to wait for.
                        r_cnt  <= '0;
                        r_tick <= 1'b0;
                        r_sq   <= 1'b0;
                        if (r_pend) begin
                            r_div  <= r_shadow;
                            r_pend <= 1'b0;
                        end
                    end else begin
                        r_tick <= w_wrap;
                        r_sq   <= (r_cnt >= (r_div >> 1));
                        if (w_wrap) begin
                            // Old period is complete; switch divisor here.
                            r_cnt <= '0;
                            if (r_pend) begin
                                r_div  <= r_shadow;
                                r_pend <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + c_one;
                        end
                    end

                    // Accept only happens with r_pend low, so it never
                    // collides with an apply on the same channel.
                    if (w_acc) begin
                        r_shadow <= cfg_div;
                        r_pend   <= 1'b1;
                    end
                end
            end

            assign tick_o[gi] = r_tick;
            assign sq_o[gi]   = r_sq;
            assign w_pend[gi] = r_pend;

`ifdef CLKDIV_TICKCNT_EN
            logic [15:0] r_tickcnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tickcnt <= 16'd0;
                end else if (sync_i) begin
                    r_tickcnt <= 16'd0;
                end else if (r_tick) begin
                    r_tickcnt <= r_tickcnt + 16'd1;
                end
            end

            assign tickcnt_o[gi*16 +: 16] = r_tickcnt;
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_clkdiv_prog
// Description : Directed self-checking bench for clkdiv_prog with the default
//               parameters. cyc counts rising edges since reset release, so
//               at the falling edge after edge k the outputs show the state
//               produced by edge k. Inputs are driven on falling edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clkdiv_prog;

    localparam int NCH = 3;
    localparam int CW  = 26;

    logic           clk       = 1'b0;
    logic           rst       = 1'b1;
    logic           sync_i    = 1'b0;
    logic           cfg_valid = 1'b0;
    logic [2:0]     cfg_ch    = 3'd0;
    logic [CW-1:0]  cfg_div   = '0;
    logic           cfg_ready;
    logic [NCH-1:0] tick_o;
    logic [NCH-1:0] sq_o;
    logic [NCH-1:0] busy_o;
`ifdef CLKDIV_TICKCNT_EN
    logic [NCH*16-1:0] tickcnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int cyc;

    clkdiv_prog dut (
        .clk       (clk),
        .rst       (rst),
        .sync_i    (sync_i),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .tick_o    (tick_o),
        .sq_o      (sq_o),
        .busy_o    (busy_o)
`ifdef CLKDIV_TICKCNT_EN
        ,
        .tickcnt_o (tickcnt_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic wait_cyc(input int target);
        int guard = 0;
        while (cyc < target && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (cyc != target) begin
            errors++;
            $display("FAIL wait_cyc: at cycle %0d, wanted cycle %0d", cyc, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tick_o !== 3'b000) begin errors++; $display("FAIL rst_tick: got %b exp 000", tick_o); end
        checks++;
        if (sq_o !== 3'b000) begin errors++; $display("FAIL rst_sq: got %b exp 000", sq_o); end
        checks++;
        if (busy_o !== 3'b000) begin errors++; $display("FAIL rst_busy: got %b exp 000", busy_o); end
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", cfg_ready); end
        rst = 1'b0;
        wait_cyc(1);
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_after_rst: got %b exp 1", cfg_ready); end
        checks++;
        if ({tick_o, sq_o} !== 6'b000000) begin errors++; $display("FAIL first_cycle_out: got %b exp 000000", {tick_o, sq_o}); end
    endtask

    // ch2 gets div=1 now; it must only take effect at the 65536-cycle wrap.
    task automatic test_cfg_ch2();
        cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 26'd1;
        wait_cyc(2);
        cfg_valid = 1'b0;
        #1;
        checks++;
        if (busy_o !== 3'b100) begin errors++; $display("FAIL ch2_busy: got %b exp 100", busy_o); end
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL ch2_ready_blocked: got %b exp 0", cfg_ready); end
        cfg_ch = 3'd0;
    endtask

    task automatic test_default_period();
        logic et, es;
        for (int k = 3; k <= 10; k++) begin
            wait_cyc(k);
            et = (k % 4 == 0);
            es = (k % 4 == 3) || (k % 4 == 0);
            checks++;
            if ({tick_o[0], sq_o[0]} !== {et, es}) begin
                errors++;
                $display("FAIL ch0_div4 k=%0d: tick/sq got %b%b exp %b%b", k, tick_o[0], sq_o[0], et, es);
            end
        end
    endtask

    task automatic test_reprogram();
        logic et, es;
        int   m;
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 26'd5;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ch0_ready: got %b exp 1", cfg_ready); end
        wait_cyc(11);
        cfg_div = 26'd9;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL ch0_second_write: ready got %b exp 0", cfg_ready); end
        checks++;
        if (busy_o[0] !== 1'b1) begin errors++; $display("FAIL ch0_busy: got %b exp 1", busy_o[0]); end
        wait_cyc(12);
        cfg_valid = 1'b0;
        checks++;
        if ({tick_o[0], sq_o[0], busy_o[0]} !== 3'b110) begin
            errors++;
            $display("FAIL ch0_wrap: tick/sq/busy got %b exp 110", {tick_o[0], sq_o[0], busy_o[0]});
        end
        for (int k = 13; k <= 22; k++) begin
            wait_cyc(k);
            m  = (k - 13) % 5;
            et = (m == 4);
            es = (m >= 2);
            checks++;
            if ({tick_o[0], sq_o[0]} !== {et, es}) begin
                errors++;
                $display("FAIL ch0_div5 k=%0d: tick/sq got %b%b exp %b%b", k, tick_o[0], sq_o[0], et, es);
            end
        end
    endtask

    task automatic test_halt_restart();
        wait_cyc(2047);
        checks++;
        if (tick_o[1] !== 1'b0) begin errors++; $display("FAIL ch1_pre_tick: got %b exp 0", tick_o[1]); end
        wait_cyc(2048);
        checks++;
        if (tick_o[1] !== 1'b1) begin errors++; $display("FAIL ch1_first_tick: got %b exp 1", tick_o[1]); end
        wait_cyc(2050);
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 26'd0;
        wait_cyc(2051);
        cfg_valid = 1'b0;
        checks++;
        if (busy_o[1] !== 1'b1) begin errors++; $display("FAIL ch1_busy0: got %b exp 1", busy_o[1]); end
        wait_cyc(4095);
        checks++;
        if ({tick_o[1], busy_o[1]} !== 2'b01) begin errors++; $display("FAIL ch1_before_wrap: tick/busy got %b exp 01", {tick_o[1], busy_o[1]}); end
        wait_cyc(4096);
        checks++;
        if ({tick_o[1], busy_o[1]} !== 2'b10) begin errors++; $display("FAIL ch1_wrap: tick/busy got %b exp 10", {tick_o[1], busy_o[1]}); end
        for (int k = 4097; k <= 4119; k++) begin
            wait_cyc(k);
            checks++;
            if ({tick_o[1], sq_o[1]} !== 2'b00) begin
                errors++;
                $display("FAIL ch1_halted k=%0d: tick/sq got %b exp 00", k, {tick_o[1], sq_o[1]});
            end
        end
        wait_cyc(4120);
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 26'd7;
        wait_cyc(4121);
        cfg_valid = 1'b0;
        checks++;
        if (busy_o[1] !== 1'b1) begin errors++; $display("FAIL ch1_busy7: got %b exp 1", busy_o[1]); end
        wait_cyc(4122);
        checks++;
        if ({tick_o[1], busy_o[1]} !== 2'b00) begin errors++; $display("FAIL ch1_load7: tick/busy got %b exp 00", {tick_o[1], busy_o[1]}); end
        wait_cyc(4128);
        checks++;
        if (tick_o[1] !== 1'b0) begin errors++; $display("FAIL ch1_div7_early: got %b exp 0", tick_o[1]); end
        wait_cyc(4129);
        checks++;
        if (tick_o[1] !== 1'b1) begin errors++; $display("FAIL ch1_div7_tick: got %b exp 1", tick_o[1]); end
        cfg_ch = 3'd0;
    endtask

    task automatic test_div1();
        wait_cyc(65535);
        checks++;
        if ({tick_o[2], sq_o[2], busy_o[2]} !== 3'b011) begin
            errors++;
            $display("FAIL ch2_before_wrap: tick/sq/busy got %b exp 011", {tick_o[2], sq_o[2], busy_o[2]});
        end
        wait_cyc(65536);
        checks++;
        if ({tick_o[2], busy_o[2]} !== 2'b10) begin errors++; $display("FAIL ch2_wrap: tick/busy got %b exp 10", {tick_o[2], busy_o[2]}); end
        for (int k = 65537; k <= 65540; k++) begin
            wait_cyc(k);
            checks++;
            if ({tick_o[2], sq_o[2]} !== 2'b11) begin
                errors++;
                $display("FAIL ch2_div1 k=%0d: tick/sq got %b exp 11", k, {tick_o[2], sq_o[2]});
            end
        end
    endtask

    task automatic test_sync();
        wait_cyc(65543);
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 26'd3;
        wait_cyc(65544);
        cfg_valid = 1'b0;
        // ch1 wraps at edge 65547 and picks up div=3 there.
        wait_cyc(65547);
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 26'd3;
        wait_cyc(65548);
        cfg_valid = 1'b0;
        checks++;
        if (busy_o !== 3'b001) begin errors++; $display("FAIL sync_pre_busy: got %b exp 001", busy_o); end
        wait_cyc(65549);
        sync_i = 1'b1;
        wait_cyc(65550);
        sync_i = 1'b0;
        checks++;
        if (tick_o !== 3'b000) begin errors++; $display("FAIL sync_no_tick: got %b exp 000", tick_o); end
        checks++;
        if (busy_o !== 3'b000) begin errors++; $display("FAIL sync_busy: got %b exp 000", busy_o); end
        wait_cyc(65551);
        checks++;
        if (tick_o !== 3'b100) begin errors++; $display("FAIL sync_t1: got %b exp 100", tick_o); end
        wait_cyc(65552);
        checks++;
        if (tick_o !== 3'b100) begin errors++; $display("FAIL sync_t2: got %b exp 100", tick_o); end
        wait_cyc(65553);
        checks++;
        if (tick_o !== 3'b111) begin errors++; $display("FAIL sync_t3: got %b exp 111", tick_o); end
        cfg_ch = 3'd0;
    endtask

    task automatic test_bad_channel();
        wait_cyc(65560);
        cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_div = 26'd9;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL bad_ch5_ready: got %b exp 0", cfg_ready); end
        cfg_ch = 3'd3;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL bad_ch3_ready: got %b exp 0", cfg_ready); end
        wait_cyc(65561);
        checks++;
        if (busy_o !== 3'b000) begin errors++; $display("FAIL bad_ch_busy: got %b exp 000", busy_o); end
        wait_cyc(65562);
        cfg_valid = 1'b0; cfg_ch = 3'd0;
        checks++;
        if (tick_o !== 3'b111) begin errors++; $display("FAIL bad_ch_tick_a: got %b exp 111", tick_o); end
        wait_cyc(65563);
        checks++;
        if ({tick_o, busy_o} !== 6'b100000) begin errors++; $display("FAIL bad_ch_tick_b: tick/busy got %b exp 100000", {tick_o, busy_o}); end
    endtask

    task automatic test_reset_pending();
        logic et, es;
        wait_cyc(65570);
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 26'd9;
        wait_cyc(65571);
        cfg_valid = 1'b0;
        checks++;
        if (busy_o !== 3'b001) begin errors++; $display("FAIL rp_busy: got %b exp 001", busy_o); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({tick_o, sq_o, busy_o, cfg_ready} !== 10'b0) begin
            errors++;
            $display("FAIL rp_async: tick/sq/busy/ready got %b exp 0000000000", {tick_o, sq_o, busy_o, cfg_ready});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            wait_cyc(k);
            et = (k % 4 == 0);
            es = (k % 4 == 3) || (k % 4 == 0);
            checks++;
            if ({tick_o[0], sq_o[0], busy_o[0]} !== {et, es, 1'b0}) begin
                errors++;
                $display("FAIL rp_ch0 k=%0d: tick/sq/busy got %b exp %b", k, {tick_o[0], sq_o[0], busy_o[0]}, {et, es, 1'b0});
            end
        end
        checks++;
        if (sq_o[2] !== 1'b0) begin errors++; $display("FAIL rp_ch2_sq: got %b exp 0", sq_o[2]); end
        wait_cyc(1024);
        checks++;
        if (sq_o[1] !== 1'b0) begin errors++; $display("FAIL rp_ch1_sq_lo: got %b exp 0", sq_o[1]); end
        wait_cyc(1025);
        checks++;
        if (sq_o[1] !== 1'b1) begin errors++; $display("FAIL rp_ch1_sq_hi: got %b exp 1", sq_o[1]); end
    endtask

    initial begin
        test_reset();
        test_cfg_ch2();
        test_default_period();
        test_reprogram();
        test_halt_restart();
        test_div1();
        test_sync();
        test_bad_channel();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
